pattern_scan_ctrl: RTL and testbench
====================================

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter and threshold.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_we  input  1  configuration write strobe; ignored while busy=1.
REQ-006 SHALL have port cfg_pattern  input  PAT_W  pattern to detect; MSB is the oldest bit.
REQ-007 SHALL have port cfg_threshold  input  CNT_W  irq threshold; value 0 disables irq.
REQ-008 SHALL have port start  input  1  begin a scan; ignored while busy=1.
REQ-009 SHALL have port in_valid  input  1  input byte valid.
REQ-010 SHALL have port in_ready  output  1  input byte accepted when in_valid=1 and in_ready=1 on the same edge.
REQ-011 SHALL have port in_data  input  8  input byte, serialised MSB first.
REQ-012 SHALL have port in_last  input  1  marks the final byte of the scan.
REQ-013 SHALL have port match_pulse  output  1  one-cycle pulse per detected match.
REQ-014 SHALL have port match_count  output  CNT_W  matches counted in the current or last scan.
REQ-015 SHALL have port busy  output  1  high in SCAN and DONE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at the end of a scan.
REQ-017 SHALL have port irq  output  1  sticky threshold-reached flag.

Function
REQ-018 SHALL implement FSM states IDLE, SCAN and DONE; transitions: IDLE->SCAN on start, SCAN->DONE after the last bit of the in_last byte is processed, DONE->IDLE unconditionally after one cycle.
REQ-019 In IDLE, cfg_we=1 SHALL latch cfg_pattern and cfg_threshold into internal registers.
REQ-020 On start in IDLE, the block SHALL clear match_count, the history register, the valid-bit count and irq.
REQ-021 In SCAN, the block SHALL hold one byte and process one bit per cycle, MSB first, shifting each bit into a PAT_W-bit history register.
REQ-022 in_ready SHALL be 1 only in SCAN when no byte is held, or when the held byte is on its last bit; back-to-back bytes therefore stream at 8 cycles per byte with no bubble.
REQ-023 in_ready SHALL be 0 in IDLE and DONE, and after the in_last byte has been accepted.
REQ-024 A match SHALL occur when at least PAT_W valid bits are held and the history equals the latched pattern; a match SHALL be detected across byte boundaries.
REQ-025 match_pulse SHALL assert in the cycle after the completing bit is shifted in; match_count SHALL increment in that same cycle and saturate at all-ones.
REQ-026 irq SHALL set in the cycle match_count first reaches a non-zero threshold (match_count >= threshold) and SHALL hold until the next start or reset.
REQ-027 done SHALL be 1 only in DONE; match_count SHALL hold its value through DONE and IDLE until the next start.
REQ-028 If a match completes on the final bit, match_pulse SHALL coincide with done, and the final count SHALL include that match.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE with in_ready=0, match_pulse=0, match_count=0, busy=0, done=0, irq=0, the history cleared, the pattern register at 0 and the threshold register at 0.
REQ-030 Reset mid-scan SHALL discard the held byte and all progress immediately; the first edge after release SHALL be in IDLE.

Configuration
REQ-031 With macro PATTERN_SCAN_OVERLAP_EN defined, the history and valid-bit count SHALL be kept after a match, so overlapping matches are counted.
REQ-032 Without PATTERN_SCAN_OVERLAP_EN, the valid-bit count SHALL clear on a match, so the next match needs PAT_W fresh bits.

Verification
REQ-033 Pattern 1101, threshold 2, single byte 0xDA with in_last -> with the macro: 2 match_pulses, match_count=2, irq=1; without the macro: 1 match_pulse, match_count=1, irq=0.
REQ-034 Pattern 1101, threshold 1, byte 0xFF with in_last -> done after 8 processing cycles, match_count=0, irq=0.
REQ-035 Pattern 1101, bytes 0x01 then 0xA0 (last) streamed back-to-back -> in_ready never drops between the bytes, 1 cross-boundary match on bit 11, match_count=1.
REQ-036 Assert rst_n=0 on the 3rd bit of byte 0xDA -> all outputs return to 0 asynchronously; a new start then scans normally from a cleared count.
REQ-037 Set CNT_W=2, pattern 11, threshold 0, byte 0xFF -> match_count saturates at 3, irq stays 0; cfg_we pulsed while busy -> the latched pattern is unchanged.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serial bit-pattern scanner with match counting and threshold irq.
//
// Bytes arrive on a valid/ready handshake and are shifted out MSB first, one bit per
// cycle, into a PAT_W-bit history register. Each time the history equals the latched
// pattern (with at least PAT_W valid bits seen), a one-cycle match_pulse is raised and
// match_count increments (saturating). irq is a sticky flag that sets once match_count
// reaches a non-zero threshold.
//
// Optional feature macro: PATTERN_SCAN_OVERLAP_EN
//   defined   : history and valid-bit count are kept after a match (overlapping matches)
//   undefined : valid-bit count clears on a match (next match needs PAT_W fresh bits)
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   cfg_we         latches cfg_pattern / cfg_threshold while idle
//   cfg_pattern    pattern to detect, MSB is the oldest bit
//   cfg_threshold  irq threshold, 0 disables irq
//   start          begins a scan while idle
//   in_valid/in_ready/in_data/in_last   byte input stream, in_last marks the final byte
//   match_pulse    one-cycle pulse per detected match
//   match_count    matches counted in the current or last scan
//   busy           high while scanning or done
//   done           one-cycle pulse at the end of a scan
//   irq            sticky threshold-reached flag
module pattern_scan_ctrl #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    localparam int unsigned VW = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic [CNT_W-1:0]   threshold_q, threshold_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [VW-1:0]      vcnt_q, vcnt_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               held_q, held_d;
    // Set once the in_last byte is accepted; also marks the held byte as the final one.
    logic               last_q, last_d;
    logic               pulse_q, pulse_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_q, irq_d;

    logic               accept;
    logic [PAT_W-1:0]   hist_nxt;
    logic [VW-1:0]      vcnt_nxt;
    logic [CNT_W-1:0]   count_nxt;

    // A new byte can be taken when nothing is held or the held byte is on its last bit.
    assign in_ready = (state_q == StScan) && !last_q && (!held_q || (bit_idx_q == 3'd7));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        threshold_d = threshold_q;
        hist_d      = hist_q;
        vcnt_d      = vcnt_q;
        byte_d      = byte_q;
        bit_idx_d   = bit_idx_q;
        held_d      = held_q;
        last_d      = last_q;
        pulse_d     = 1'b0;
        count_d     = count_q;
        irq_d       = irq_q;
        hist_nxt    = '0;
        vcnt_nxt    = '0;
        count_nxt   = '0;

        unique case (state_q)
            StIdle: begin
                if (cfg_we) begin
                    pattern_d   = cfg_pattern;
                    threshold_d = cfg_threshold;
                end
                if (start) begin
                    state_d = StScan;
                    hist_d  = '0;
                    vcnt_d  = '0;
                    held_d  = 1'b0;
                    last_d  = 1'b0;
                    count_d = '0;
                    irq_d   = 1'b0;
                end
            end
            StScan: begin
                if (held_q) begin
                    hist_nxt  = {hist_q[PAT_W-2:0], byte_q[7]};
                    vcnt_nxt  = (vcnt_q == VW'(PAT_W)) ? vcnt_q : vcnt_q + VW'(1);
                    hist_d    = hist_nxt;
                    vcnt_d    = vcnt_nxt;
                    byte_d    = {byte_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if ((vcnt_nxt == VW'(PAT_W)) && (hist_nxt == pattern_q)) begin
                        pulse_d   = 1'b1;
                        count_nxt = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        count_d   = count_nxt;
                        if ((threshold_q != '0) && (count_nxt >= threshold_q)) begin
                            irq_d = 1'b1;
                        end
`ifndef PATTERN_SCAN_OVERLAP_EN
                        vcnt_d = '0;
`endif
                    end
                    if (bit_idx_q == 3'd7) begin
                        held_d = 1'b0;
                        if (last_q) begin
                            state_d = StDone;
                        end
                    end
                end
                if (accept) begin
                    byte_d    = in_data;
                    bit_idx_d = 3'd0;
                    held_d    = 1'b1;
                    last_d    = in_last;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pattern_q   <= '0;
            threshold_q <= '0;
            hist_q      <= '0;
            vcnt_q      <= '0;
            byte_q      <= '0;
            bit_idx_q   <= '0;
            held_q      <= 1'b0;
            last_q      <= 1'b0;
            pulse_q     <= 1'b0;
            count_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            threshold_q <= threshold_d;
            hist_q      <= hist_d;
            vcnt_q      <= vcnt_d;
            byte_q      <= byte_d;
            bit_idx_q   <= bit_idx_d;
            held_q      <= held_d;
            last_q      <= last_d;
            pulse_q     <= pulse_d;
            count_q     <= count_d;
            irq_q       <= irq_d;
        end
    end

    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign irq         = irq_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: table-driven bench with a scoreboard queue for pattern_scan_ctrl.
// A second instance with CNT_W=2, PAT_W=2 covers count saturation and busy-time cfg_we.
module tb_pattern_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic [7:0] cfg_threshold;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       irq;

    logic       cfg_we2;
    logic [1:0] cfg_pattern2;
    logic [1:0] cfg_threshold2;
    logic       start2;
    logic       in_valid2;
    logic       in_ready2;
    logic [7:0] in_data2;
    logic       in_last2;
    logic       match_pulse2;
    logic [1:0] match_count2;
    logic       busy2;
    logic       done2;
    logic       irq2;

    pattern_scan_ctrl #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_threshold(cfg_threshold), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .match_pulse(match_pulse), .match_count(match_count), .busy(busy),
        .done(done), .irq(irq)
    );

    pattern_scan_ctrl #(.PAT_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we2), .cfg_pattern(cfg_pattern2),
        .cfg_threshold(cfg_threshold2), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
        .match_pulse(match_pulse2), .match_count(match_count2), .busy(busy2),
        .done(done2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pat;
        logic [7:0] thr;
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        int         pulses;
        int         cnt;
        int         irq;
        int         last;
    } vec_t;

    typedef struct {
        int pulses;
        int cnt;
        int irq;
        int last;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pulses_seen = 0;
    int last_hit = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (match_pulse) pulses_seen++;
        if (match_pulse && done) last_hit = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   t;
        int   acc0;
        int   acc_last;
        acc0     = 0;
        acc_last = 0;
        @(negedge clk);
        cfg_we        = 1'b1;
        cfg_pattern   = v.pat;
        cfg_threshold = v.thr;
        @(negedge clk);
        cfg_we = 1'b0;
        start  = 1'b1;
        e.pulses = v.pulses;
        e.cnt    = v.cnt;
        e.irq    = v.irq;
        e.last   = v.last;
        sb.push_back(e);
        pulses_seen = 0;
        last_hit    = 0;
        tick();
        start = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            in_valid = 1'b1;
            in_data  = (b == 0) ? v.b0 : v.b1;
            in_last  = (b == v.nb - 1);
            t = 0;
            while (!in_ready && t < 40) begin
                tick();
                t++;
            end
            if (!in_ready) timeout($sformatf("v%0d_ready", idx));
            if (b == 0) acc0 = cyc;
            else check($sformatf("v%0d_stream_gap", idx), cyc - acc0, 8);
            acc_last = cyc;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check($sformatf("v%0d_ready_after_last", idx), int'(in_ready), 0);
        t = 0;
        while (!done && t < 40) begin
            tick();
            t++;
        end
        if (!done) timeout($sformatf("v%0d_done", idx));
        check($sformatf("v%0d_latency", idx), cyc - acc_last - 1, 8);
        got = sb.pop_front();
        check($sformatf("v%0d_count", idx), int'(match_count), got.cnt);
        check($sformatf("v%0d_irq", idx), int'(irq), got.irq);
        check($sformatf("v%0d_pulses", idx), pulses_seen, got.pulses);
        check($sformatf("v%0d_pulse_at_done", idx), last_hit, got.last);
        check($sformatf("v%0d_busy_in_done", idx), int'(busy), 1);
        tick();
        check($sformatf("v%0d_done_width", idx), int'(done), 0);
        check($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
        check($sformatf("v%0d_count_hold", idx), int'(match_count), got.cnt);
    endtask

    task automatic wait_done2(input string name);
        int t;
        t = 0;
        while (!done2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!done2) timeout(name);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_pattern = '0; cfg_threshold = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        cfg_we2 = 1'b0; cfg_pattern2 = '0; cfg_threshold2 = '0; start2 = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; in_last2 = 1'b0;

        //         pat      thr    b0     b1     nb  pulses cnt irq last
`ifdef PATTERN_SCAN_OVERLAP_EN
        vecs[0] = '{4'b1101, 8'd2, 8'hDA, 8'h00, 1, 2, 2, 1, 0};
        vecs[3] = '{4'b0000, 8'd3, 8'h00, 8'h00, 1, 5, 5, 1, 1};
        vecs[4] = '{4'b1010, 8'd0, 8'hAA, 8'h00, 1, 3, 3, 0, 1};
        vecs[5] = '{4'b0110, 8'd1, 8'h36, 8'h6C, 2, 4, 4, 1, 0};
`else
        vecs[0] = '{4'b1101, 8'd2, 8'hDA, 8'h00, 1, 1, 1, 0, 0};
        vecs[3] = '{4'b0000, 8'd3, 8'h00, 8'h00, 1, 2, 2, 0, 1};
        vecs[4] = '{4'b1010, 8'd0, 8'hAA, 8'h00, 1, 2, 2, 0, 1};
        vecs[5] = '{4'b0110, 8'd1, 8'h36, 8'h6C, 2, 2, 2, 1, 0};
`endif
        vecs[1] = '{4'b1101, 8'd1, 8'hFF, 8'h00, 1, 0, 0, 0, 0};
        vecs[2] = '{4'b1101, 8'd1, 8'h01, 8'hA0, 2, 1, 1, 1, 0};

        #3;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_match_pulse", int'(match_pulse), 0);
        check("rst_count", int'(match_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_irq", int'(irq), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while the 3rd bit of 0xDA is being processed.
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = 4'b1101; cfg_threshold = 8'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'hDA; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midscan_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_in_ready", int'(in_ready), 0);
        check("arst_done", int'(done), 0);
        check("arst_pulse", int'(match_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 10);

        // CNT_W=2 instance: saturation, threshold 0, and cfg_we ignored while busy.
        @(negedge clk);
        cfg_we2 = 1'b1; cfg_pattern2 = 2'b11; cfg_threshold2 = 2'd0;
        @(negedge clk);
        cfg_we2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sat_ready", int'(in_ready2), 1);
        in_valid2 = 1'b1; in_data2 = 8'hFF; in_last2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0; in_last2 = 1'b0;
        cfg_we2 = 1'b1; cfg_pattern2 = 2'b00; cfg_threshold2 = 2'd1;
        @(negedge clk);
        cfg_we2 = 1'b0;
        wait_done2("sat_done");
        check("sat_count", int'(match_count2), 3);
        check("sat_irq", int'(irq2), 0);
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        in_valid2 = 1'b1; in_data2 = 8'h03; in_last2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0; in_last2 = 1'b0;
        wait_done2("keep_done");
        check("pattern_kept_count", int'(match_count2), 1);
        check("pattern_kept_irq", int'(irq2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
